// File: rtl/song_reader_pkg.sv
// Shared definitions for the song reader: FSM states and ROM word field positions.
// Pure declarations; no logic, no latency, no flow control.
// Fields are addressed by bit position so the ROM format lives in one place.
package song_reader_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        LOAD  = 3'd2,
        PLAY  = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam int NOTE_MSB = 14;
    localparam int NOTE_LSB = 9;
    localparam int DUR_MSB  = 8;
    localparam int DUR_LSB  = 3;

    localparam int NOTE_W = NOTE_MSB - NOTE_LSB + 1;
    localparam int DUR_W  = DUR_MSB - DUR_LSB + 1;

endpackage

// File: rtl/song_reader.sv
// Steps through one song in a note ROM, holding each note for its duration in beats.
// Latency: play -> FETCH next cycle, note registered after LOAD (ROM read is 1 cycle).
// Backpressure: play low pauses PLAY in place; ROM is always ready, beats outside PLAY are dropped.
module song_reader
    import song_reader_pkg::*;
#(
    parameter int NOTE_IDX_W = 5,
    parameter int SONG_W     = 2
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         play,
    input  logic [SONG_W-1:0]            song,
    input  logic                         beat,
    output logic [NOTE_IDX_W+SONG_W-1:0] rom_addr,
    input  logic [15:0]                  rom_dout,
    output logic [NOTE_W-1:0]            note,
    output logic                         new_note,
    output logic                         playing,
    output logic                         song_done
);

    state_t                state_q, state_d;
    logic [SONG_W-1:0]     song_q, song_d;
    logic [NOTE_IDX_W-1:0] note_idx, note_idx_d;
    logic [DUR_W-1:0]      cnt_q, cnt_d;
    logic [NOTE_W-1:0]     note_q, note_d;

    logic [NOTE_W-1:0]     rom_note;
    logic [DUR_W-1:0]      rom_dur;
    logic                  rom_unused_bits;

    assign rom_note        = rom_dout[NOTE_MSB:NOTE_LSB];
    assign rom_dur         = rom_dout[DUR_MSB:DUR_LSB];
    assign rom_unused_bits = ^{rom_dout[15], rom_dout[DUR_LSB-1:0]};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            song_q   <= '0;
            note_idx <= '0;
            cnt_q    <= '0;
            note_q   <= '0;
        end else begin
            state_q  <= state_d;
            song_q   <= song_d;
            note_idx <= note_idx_d;
            cnt_q    <= cnt_d;
            note_q   <= note_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        song_d     = song_q;
        note_idx_d = note_idx;
        cnt_d      = cnt_q;
        note_d     = note_q;
        new_note   = 1'b0;

        case (state_q)
            IDLE: begin
                if (play) begin
                    song_d     = song;
                    note_idx_d = '0;
                    state_d    = FETCH;
                end
            end
            // Address is already stable; this cycle absorbs the registered ROM read.
            FETCH: state_d = LOAD;
            LOAD: begin
                if (rom_dur != '0) begin
                    note_d   = rom_note;
                    cnt_d    = rom_dur;
                    new_note = 1'b1;
                    state_d  = PLAY;
                end else begin
                    note_d  = '0;
                    cnt_d   = '0;
                    state_d = DONE;
                end
            end
            PLAY: begin
                if (beat && play) begin
                    cnt_d = cnt_q - 1'b1;
                    if (cnt_q == DUR_W'(1)) begin
                        // Last entry ends the song rather than spilling into the next song's range.
                        if (&note_idx) begin
                            note_d  = '0;
                            state_d = DONE;
                        end else begin
                            note_idx_d = note_idx + 1'b1;
                            state_d    = FETCH;
                        end
                    end
                end
            end
            DONE: begin
                note_d = '0;
                if (!play) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign rom_addr  = {song_q, note_idx};
    assign note      = note_q;
    assign playing   = (state_q == PLAY) && play;
    assign song_done = (state_q == DONE);

endmodule

// File: doc/song_reader.md
SONG_READER -- requirements
Module: song_reader

Interface
REQ-001 SHALL have parameters: NOTE_IDX_W, default 5, log2 of ROM entries per song; SONG_W, default 2, song-select width; (NOTE_IDX_W + SONG_W) equals the 7-bit ROM address width.
REQ-002 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset_n  input  1  reset; asynchronous assertion, active-low.
REQ-004 SHALL have port play  input  1  level; high = run or resume, low = pause.
REQ-005 SHALL have port song  input  SONG_W  song select; sampled only when leaving IDLE.
REQ-006 SHALL have port beat  input  1  one-cycle strobe per duration tick.
REQ-007 SHALL have port rom_addr  output  7  ROM read address, equal to {song_q, note_idx}.
REQ-008 SHALL have port rom_dout  input  16  ROM word; bits 14:9 note, bits 8:3 duration, bits 15 and 2:0 ignored.
REQ-009 SHALL have port note  output  6  current note code; 0 means rest.
REQ-010 SHALL have port new_note  output  1  one-cycle pulse when note takes a newly loaded value.
REQ-011 SHALL have port playing  output  1  high while in PLAY with play high.
REQ-012 SHALL have port song_done  output  1  high while in DONE.

Function
REQ-013 SHALL implement the states IDLE, FETCH, LOAD, PLAY and DONE.
REQ-014 IDLE: on play high, SHALL latch song into song_q, clear note_idx and go to FETCH.
REQ-015 FETCH SHALL last exactly 1 cycle while rom_addr is held stable, covering the ROM's 1-cycle registered read latency, then go to LOAD.
REQ-016 LOAD with duration != 0 SHALL register note and duration, set the beat counter to duration, pulse new_note for that cycle, and go to PLAY.
REQ-017 LOAD with duration == 0 SHALL go to DONE without a pulse on new_note, with note set to 0.
REQ-018 PLAY SHALL decrement the counter only on cycles where beat and play are both high.
REQ-019 PLAY: when the counter goes from 1 to 0, if note_idx equals all-ones the block SHALL go to DONE; otherwise it SHALL increment note_idx and go to FETCH.
REQ-020 PLAY with play low (pause) SHALL hold the counter, note and note_idx; playing SHALL be low while paused.
REQ-021 A beat strobe arriving in FETCH, LOAD, IDLE or DONE SHALL be ignored and not counted.
REQ-022 A note held for duration D SHALL remain on note for exactly D counted beats.
REQ-023 DONE SHALL hold song_done high with note at 0, and SHALL return to IDLE only when play is low.
REQ-024 A change on song after leaving IDLE SHALL have no effect until the next IDLE exit.
REQ-025 note_idx SHALL never wrap into the next song's address range.

Reset
REQ-026 While reset_n is low, the block SHALL be in state IDLE with song_q=0, note_idx=0, counter=0, note=0, new_note=0, playing=0, song_done=0, and rom_addr=0.
REQ-027 Reset asserted mid-note SHALL abort the note immediately; after release, the block SHALL wait in IDLE for play.

Structure
REQ-028 The shared package SHALL hold the state enum and the field constants NOTE_MSB=14, NOTE_LSB=9, DUR_MSB=8 and DUR_LSB=3.
REQ-029 The block SHALL be a single module with no sub-modules; the beat down-counter and FSM stay inline.

Verification
REQ-030 Bench: song=1, play rising -> rom_addr=32 in FETCH; new_note pulses in LOAD; note taken from the word at address 32.
REQ-031 Bench: word with note 37, duration 3 and beats every 10 cycles -> note=37 held for exactly 3 beats, then rom_addr advances by 1.
REQ-032 Bench: word with duration 0 at index 28 -> DONE reached with song_done=1, no new_note pulse, note=0.
REQ-033 Bench: play dropped for 50 cycles mid-note with beats arriving -> counter frozen, playing=0; the note resumes with its remaining beat count intact.
REQ-034 Bench: last entry (index 31) completes -> DONE with no wrap; play low then high -> restarts at index 0 of the newly sampled song.
REQ-035 Bench: reset_n pulsed low asynchronously during PLAY -> all outputs 0 at once; IDLE after release.
